// File: rtl/test_mem_responder.sv
// Single-port memory responder for processor benches.
// Fixed-latency, in-order responses held in a small ring buffer.
package test_mem_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

module test_mem_responder
  import test_mem_pkg::*;
#(
  parameter int p_mem_nbytes = 65536,
  parameter int p_latency    = 1,
  parameter int p_resp_depth = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_req_4B_t  reqstream_msg,
  input  logic         reqstream_val,
  output logic         reqstream_rdy,
  output mem_resp_4B_t respstream_msg,
  output logic         respstream_val,
  input  logic         respstream_rdy
);

  localparam int AW = $clog2(p_mem_nbytes);
  localparam int NW = p_mem_nbytes / 4;
  localparam int PW =
    (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
  localparam int CW = $clog2(p_resp_depth + 1);
  localparam logic [3:0] TMR0 = 4'(p_latency - 1);

  logic [31:0] r_mem [NW];

  logic [2:0]  r_type [p_resp_depth];
  logic [7:0]  r_opq  [p_resp_depth];
  logic [1:0]  r_len  [p_resp_depth];
  logic [31:0] r_data [p_resp_depth];
  logic [3:0]  r_tmr  [p_resp_depth];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_acc;
  logic          w_deq;
  logic [AW-3:0] w_idx;
  logic [1:0]    w_off;
  logic [2:0]    w_nb;
  logic          w_is_wr;
  logic [31:0]   w_word;
  logic [31:0]   w_rdata;
  logic [31:0]   w_wdata;
  logic          w_unused_addr;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(p_resp_depth - 1)) ?
      '0 : p + 1'b1;
  endfunction

  assign w_unused_addr = ^reqstream_msg.addr[31:AW];

  assign reqstream_rdy =
    !reset && (r_count < CW'(p_resp_depth));
  assign respstream_val =
    !reset && (r_count != '0) &&
    (r_tmr[r_head] == 4'd0);

  assign w_acc = reqstream_val && reqstream_rdy;
  assign w_deq = respstream_val && respstream_rdy;

  assign w_idx = reqstream_msg.addr[AW-1:2];
  assign w_off = reqstream_msg.addr[1:0];
  assign w_nb  = (reqstream_msg.len == 2'd0) ?
    3'd4 : {1'b0, reqstream_msg.len};
  assign w_is_wr = (reqstream_msg.type_ == 3'd1) ||
                   (reqstream_msg.type_ == 3'd2);
  assign w_word = r_mem[w_idx];

  // Bytes that would fall past the word are dropped.
  always_comb begin
    w_rdata = '0;
    w_wdata = w_word;
    for (int b = 0; b < 4; b++) begin
      if ((b < int'(w_nb)) &&
          (int'(w_off) + b < 4))
        w_rdata[8*b +: 8] =
          w_word[8*(int'(w_off) + b) +: 8];
      if ((b >= int'(w_off)) &&
          (b - int'(w_off) < int'(w_nb)))
        w_wdata[8*b +: 8] =
          reqstream_msg.data[8*(b - int'(w_off)) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && w_is_wr)
      r_mem[w_idx] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < p_resp_depth; i++)
        r_tmr[i] <= 4'd0;
    end else begin
      for (int i = 0; i < p_resp_depth; i++)
        if (r_tmr[i] != 4'd0)
          r_tmr[i] <= r_tmr[i] - 4'd1;
      if (w_acc) begin
        r_type[r_tail] <= reqstream_msg.type_;
        r_opq[r_tail]  <= reqstream_msg.opaque;
        r_len[r_tail]  <= reqstream_msg.len;
        r_data[r_tail] <= w_is_wr ? 32'd0 : w_rdata;
        r_tmr[r_tail]  <= TMR0;
        r_tail         <= f_inc(r_tail);
      end
      if (w_deq)
        r_head <= f_inc(r_head);
      unique case ({w_acc, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    respstream_msg        = '0;
    respstream_msg.type_  = r_type[r_head];
    respstream_msg.opaque = r_opq[r_head];
    respstream_msg.test   = 2'b00;
    respstream_msg.len    = r_len[r_head];
    respstream_msg.data   = r_data[r_head];
  end

endmodule

// File: tb/tb_test_mem_responder.sv
// Bench for test_mem_responder: three configurations,
// queue scoreboard checked by an independent monitor.
module tb_test_mem_responder;
  import test_mem_pkg::*;

  typedef struct {
    mem_resp_4B_t msg;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_req_4B_t  rq [3];
  logic         rv [3];
  logic         rr [3];
  mem_resp_4B_t sm [3];
  logic         sv [3];
  logic         sr [3];
  exp_t         sbq [3][$];

  test_mem_responder #(
    .p_mem_nbytes(65536), .p_latency(1), .p_resp_depth(2)
  ) u0 (
    .clk(clk), .reset(reset),
    .reqstream_msg(rq[0]), .reqstream_val(rv[0]),
    .reqstream_rdy(rr[0]),
    .respstream_msg(sm[0]), .respstream_val(sv[0]),
    .respstream_rdy(sr[0])
  );

  test_mem_responder #(
    .p_mem_nbytes(65536), .p_latency(3), .p_resp_depth(2)
  ) u1 (
    .clk(clk), .reset(reset),
    .reqstream_msg(rq[1]), .reqstream_val(rv[1]),
    .reqstream_rdy(rr[1]),
    .respstream_msg(sm[1]), .respstream_val(sv[1]),
    .respstream_rdy(sr[1])
  );

  test_mem_responder #(
    .p_mem_nbytes(65536), .p_latency(2), .p_resp_depth(3)
  ) u2 (
    .clk(clk), .reset(reset),
    .reqstream_msg(rq[2]), .reqstream_val(rv[2]),
    .reqstream_rdy(rr[2]),
    .respstream_msg(sm[2]), .respstream_val(sv[2]),
    .respstream_rdy(sr[2])
  );

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (sv[k] === 1'b1 && sr[k] === 1'b1) begin
        n_chk++;
        if (sbq[k].size() == 0) begin
          n_fail++;
          $display("FAIL u%0d unexpected resp got %h",
                   k, sm[k]);
        end else begin
          e = sbq[k].pop_front();
          if (sm[k] !== e.msg ||
              (e.cyc >= 0 && cyc != e.cyc)) begin
            n_fail++;
            $display("FAIL u%0d resp got %h @%0d exp %h @%0d",
                     k, sm[k], cyc, e.msg, e.cyc);
          end
        end
      end
    end
  end

  // lat > 0: response must appear lat cycles after accept
  task automatic send(int k, logic [2:0] t, logic [7:0] op,
                      logic [31:0] a, logic [1:0] ln,
                      logic [31:0] d, logic [31:0] rdat,
                      int lat);
    exp_t e;
    int   n;
    int   nb;
    rq[k] = '{type_: t, opaque: op, addr: a,
              len: ln, data: d};
    rv[k] = 1'b1;
    nb = (ln == 2'd0) ? 4 : int'(ln);
    n_chk++;
    if (int'(a[1:0]) + nb > 4) begin
      n_fail++;
      $display("FAIL overflow req got %h exp in-word", a);
    end
    n = 0;
    @(negedge clk);
    while (rr[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rr[k] !== 1'b1) begin
      chk("accept_timeout", 64'(rr[k]), 64'd1);
      rv[k] = 1'b0;
      return;
    end
    e.msg = '{type_: t, opaque: op, test: 2'b00, len: ln,
              data: (t == 3'd1 || t == 3'd2) ? 32'd0 : rdat};
    e.cyc = (lat > 0) ? cyc + lat : -1;
    sbq[k].push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int k);
    int n;
    rv[k] = 1'b0;
    n = 0;
    while (sbq[k].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq[k].size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int k = 0; k < 3; k++) begin
      rq[k] = '0;
      rv[k] = 1'b0;
      sr[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdy", 64'(rr[k]), 64'd0);
      chk("rst_val", 64'(sv[k]), 64'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_rdy", 64'(rr[k]), 64'd1);
      chk("post_rst_val", 64'(sv[k]), 64'd0);
    end
    @(posedge clk);
    #1;

    // init then read-after-write, latency 1
    send(0, 3'd2, 8'h00, 32'h1000, 2'd0,
         32'hdeadbeef, 32'h0, 1);
    send(0, 3'd0, 8'h05, 32'h1000, 2'd0,
         32'h0, 32'hdeadbeef, 1);
    drain(0);

    // sub-word writes and reads
    send(0, 3'd1, 8'h01, 32'h2000, 2'd0,
         32'h11223344, 32'h0, 1);
    send(0, 3'd1, 8'h02, 32'h2002, 2'd1,
         32'h000000aa, 32'h0, 1);
    send(0, 3'd0, 8'h03, 32'h2002, 2'd2,
         32'h0, 32'h000011aa, 1);
    send(0, 3'd0, 8'h04, 32'h2000, 2'd0,
         32'h0, 32'h11aa3344, 1);
    send(0, 3'd5, 8'h06, 32'h2000, 2'd0,
         32'hffffffff, 32'h11aa3344, 1);
    send(0, 3'd1, 8'h07, 32'h2001, 2'd3,
         32'h00ccbbaa, 32'h0, 1);
    send(0, 3'd0, 8'h08, 32'h2000, 2'd0,
         32'h0, 32'hccbbaa44, 1);
    send(0, 3'd0, 8'h09, 32'h2003, 2'd1,
         32'h0, 32'h000000cc, 1);
    drain(0);

    // address wrap
    send(0, 3'd1, 8'h0a, 32'h0001_0008, 2'd0,
         32'h5, 32'h0, 1);
    send(0, 3'd0, 8'h0b, 32'h0000_0008, 2'd0,
         32'h0, 32'h5, 1);
    drain(0);

    // reset with two responses pending
    sr[0] = 1'b0;
    send(0, 3'd0, 8'h0c, 32'h8, 2'd0, 32'h0, 32'h5, -1);
    send(0, 3'd0, 8'h0d, 32'h8, 2'd0, 32'h0, 32'h5, -1);
    rv[0] = 1'b0;
    @(negedge clk);
    chk("pend_val", 64'(sv[0]), 64'd1);
    chk("pend_full_rdy", 64'(rr[0]), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    sbq[0].delete();
    @(negedge clk);
    chk("midrst_val", 64'(sv[0]), 64'd0);
    chk("midrst_rdy", 64'(rr[0]), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("after_rst_val", 64'(sv[0]), 64'd0);
    chk("after_rst_rdy", 64'(rr[0]), 64'd1);
    @(posedge clk);
    #1 sr[0] = 1'b1;
    send(0, 3'd0, 8'h0e, 32'h8, 2'd0, 32'h0, 32'h5, 1);
    drain(0);

    // back-pressure, latency 3 depth 2
    send(1, 3'd2, 8'h00, 32'h40, 2'd0,
         32'ha0a0a0a0, 32'h0, -1);
    send(1, 3'd2, 8'h01, 32'h44, 2'd0,
         32'ha1a1a1a1, 32'h0, -1);
    send(1, 3'd2, 8'h02, 32'h48, 2'd0,
         32'ha2a2a2a2, 32'h0, -1);
    drain(1);
    sr[1] = 1'b0;
    c0 = cyc;
    send(1, 3'd0, 8'h20, 32'h40, 2'd0,
         32'h0, 32'ha0a0a0a0, -1);
    send(1, 3'd0, 8'h21, 32'h44, 2'd0,
         32'h0, 32'ha1a1a1a1, -1);
    chk("bp_two_accepts", 64'(cyc - c0), 64'd2);
    rq[1] = '{type_: 3'd0, opaque: 8'h22, addr: 32'h48,
              len: 2'd0, data: 32'h0};
    rv[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_rdy_low", 64'(rr[1]), 64'd0);
    end
    chk("bp_val_held", 64'(sv[1]), 64'd1);
    sr[1] = 1'b1;
    send(1, 3'd0, 8'h22, 32'h48, 2'd0,
         32'h0, 32'ha2a2a2a2, -1);
    drain(1);

    // streaming, latency 2 depth 3
    for (int i = 0; i < 8; i++)
      send(2, 3'd2, 8'(i), 32'(4 * i), 2'd0,
           32'h1000_0000 + 32'(i), 32'h0, -1);
    drain(2);
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(2, 3'd0, 8'h30 + 8'(i), 32'(4 * i), 2'd0,
           32'h0, 32'h1000_0000 + 32'(i), 2);
    chk("stream_rate", 64'(cyc - c0), 64'd8);
    drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
